// File: rtl/rca_shared_adder_arbiter.sv
// rca_shared_adder_arbiter: shares one ripple-carry adder among NREQ requesters with valid/ready handshakes.
// Define RCA_ARB_FIXED_PRIORITY_EN for fixed lowest-index priority instead of round-robin.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module ripple_carry_adder_61bit #(
   parameter int WIDTH = 61
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   logic [WIDTH:0] c;
   assign c[0] = 1'b0;
   assign cout = c[WIDTH];
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      full_adder fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
   end
endmodule

module rca_shared_adder_arbiter #(
   parameter int WIDTH       = 61,
   parameter int NREQ        = 4,
   parameter int CALC_CYCLES = 2,
   localparam int IDW        = $clog2(NREQ)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [NREQ-1:0]      i_req_valid,
   input  logic [NREQ*WIDTH-1:0] i_req_a,
   input  logic [NREQ*WIDTH-1:0] i_req_b,
   output logic [NREQ-1:0]      o_req_ready,
   output logic                 o_res_valid,
   output logic [WIDTH:0]       o_res_data,
   output logic [IDW-1:0]       o_res_id,
   input  logic                 i_res_ready
);
   localparam int CW = ($clog2(CALC_CYCLES) > 0) ? $clog2(CALC_CYCLES) : 1;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t           state, state_nx;
   logic [IDW-1:0]   gnt_id;
   logic             accept;
   logic [WIDTH-1:0] op_a, op_b, sum;
   logic             cout;
   logic [CW-1:0]    cnt;
   ripple_carry_adder_61bit #(.WIDTH(WIDTH)) adder (.a(op_a), .b(op_b), .sum(sum), .cout(cout));
`ifdef RCA_ARB_FIXED_PRIORITY_EN
   always_comb begin
      gnt_id = '0;
      for (int i = NREQ-1; i >= 0; i--)
         if (i_req_valid[i]) gnt_id = IDW'(i);
   end
`else
   logic [IDW-1:0] rr_ptr;
   // descending scan so the requester closest to rr_ptr wins
   always_comb begin
      logic [IDW-1:0] idx;
      gnt_id = '0;
      idx = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         idx = IDW'((int'(rr_ptr) + i) % NREQ);
         if (i_req_valid[idx]) gnt_id = idx;
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) rr_ptr <= '0;
      else if (accept) rr_ptr <= IDW'((int'(gnt_id) + 1) % NREQ);
`endif
   assign accept = i_rst_n && state == IDLE && |i_req_valid;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      state_nx = accept ? CALC : (state == CALC && cnt == '0) ? DONE :
                 (state == DONE && i_res_ready) ? IDLE : state;
   end
   always_comb begin
      o_req_ready = accept ? (NREQ'(1) << gnt_id) : '0;
      o_res_valid = state == DONE;
   end
   // operand regs feed the adder for CALC_CYCLES before the result is sampled
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         op_a       <= '0;
         op_b       <= '0;
         cnt        <= '0;
         o_res_id   <= '0;
         o_res_data <= '0;
      end else if (accept) begin
         op_a     <= i_req_a[gnt_id*WIDTH +: WIDTH];
         op_b     <= i_req_b[gnt_id*WIDTH +: WIDTH];
         cnt      <= CW'(CALC_CYCLES - 1);
         o_res_id <= gnt_id;
      end else if (state == CALC) begin
         if (cnt == '0) o_res_data <= {cout, sum};
         else cnt <= cnt - CW'(1);
      end
endmodule

// File: tb/tb_rca_shared_adder_arbiter.sv
// tb_rca_shared_adder_arbiter: directed vector table plus handwritten backpressure, reset and fairness sequences.
module tb_rca_shared_adder_arbiter;
   localparam int W = 61, N = 4, CC = 2;
   typedef struct {
      logic [N-1:0]        valid;
      logic [N-1:0][W-1:0] a;
      logic [N-1:0][W-1:0] b;
      int                  id;
      logic [W:0]          data;
   } vec_t;
   logic           clk = 0, rst_n = 0, res_valid, res_ready;
   logic [N-1:0]   req_valid, req_ready;
   logic [N*W-1:0] req_a, req_b;
   logic [W:0]     res_data;
   logic [1:0]     res_id;
   int             n_cmp = 0, n_err = 0;
   vec_t           tv[5];
   always #5 clk = ~clk;
   rca_shared_adder_arbiter #(.WIDTH(W), .NREQ(N), .CALC_CYCLES(CC)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_a(req_a), .i_req_b(req_b),
      .o_req_ready(req_ready), .o_res_valid(res_valid), .o_res_data(res_data), .o_res_id(res_id),
      .i_res_ready(res_ready)
   );
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask
   task automatic wait_res(input string name);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!res_valid && n < 20);
      chk({name, " latency"}, 64'(n), 64'(CC));
   endtask
   initial begin
      int got[$];
      int exp_order[5];
      logic bad;
      for (int i = 0; i < 5; i++) begin
         tv[i].valid = '0; tv[i].a = '0; tv[i].b = '0;
      end
      tv[0].valid = 4'b0100; tv[0].a[2] = 61'd5; tv[0].b[2] = 61'd7; tv[0].id = 2; tv[0].data = 62'd12;
      tv[1].valid = 4'b0010; tv[1].a[1] = '1; tv[1].b[1] = '1; tv[1].id = 1;
      tv[1].data = 62'h3FFF_FFFF_FFFF_FFFE;
      tv[2].valid = 4'b1001; tv[2].a[0] = 61'd1; tv[2].b[0] = 61'd1; tv[2].a[3] = 61'd100; tv[2].b[3] = 61'd23;
`ifdef RCA_ARB_FIXED_PRIORITY_EN
      tv[2].id = 0; tv[2].data = 62'd2;
      exp_order = '{0, 0, 0, 0, 0};
`else
      tv[2].id = 3; tv[2].data = 62'd123;
      exp_order = '{0, 1, 2, 3, 0};
`endif
      tv[3].valid = 4'b1001; tv[3].a[0] = 61'd1; tv[3].b[0] = 61'd1; tv[3].a[3] = 61'd100; tv[3].b[3] = 61'd23;
      tv[3].id = 0; tv[3].data = 62'd2;
      tv[4].valid = 4'b0001; tv[4].a[0] = 61'h1000_0000_0000_0000; tv[4].b[0] = 61'h1000_0000_0000_0000;
      tv[4].id = 0; tv[4].data = 62'h2000_0000_0000_0000;
      req_valid = '1; req_a = '0; req_b = '0; res_ready = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset ready", 64'(req_ready), 64'd0);
      chk("reset valid", 64'(res_valid), 64'd0);
      chk("reset data", 64'(res_data), 64'd0);
      chk("reset id", 64'(res_id), 64'd0);
      rst_n = 1; req_valid = '0;
      for (int i = 0; i < 5; i++) begin
         req_valid = tv[i].valid; req_a = tv[i].a; req_b = tv[i].b;
         #1;
         chk($sformatf("v%0d ready", i), 64'(req_ready), 64'(4'b0001 << tv[i].id));
         @(posedge clk); #1;
         req_valid = '0;
         wait_res($sformatf("v%0d", i));
         chk($sformatf("v%0d data", i), 64'(res_data), 64'(tv[i].data));
         chk($sformatf("v%0d id", i), 64'(res_id), 64'(tv[i].id));
         @(posedge clk); #1;
         chk($sformatf("v%0d valid drop", i), 64'(res_valid), 64'd0);
      end
      res_ready = 0; req_valid = 4'b1000; req_a[3*W +: W] = 61'd9; req_b[3*W +: W] = 61'd9;
      #1;
      chk("bp ready", 64'(req_ready), 64'b1000);
      @(posedge clk); #1;
      req_valid = '1; req_a[3*W +: W] = 61'd50;
      wait_res("bp");
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         chk($sformatf("bp%0d valid", c), 64'(res_valid), 64'd1);
         chk($sformatf("bp%0d data", c), 64'(res_data), 64'd18);
         chk($sformatf("bp%0d id", c), 64'(res_id), 64'd3);
         chk($sformatf("bp%0d ready", c), 64'(req_ready), 64'd0);
      end
      res_ready = 1;
      @(posedge clk); #1;
      chk("bp release valid", 64'(res_valid), 64'd0);
      chk("bp release idle", 64'(req_ready), 64'b0001);
      req_valid = 4'b0010; req_a[W +: W] = 61'd3; req_b[W +: W] = 61'd4;
      #1;
      chk("rst ready", 64'(req_ready), 64'b0010);
      @(posedge clk); #1;
      req_valid = '0;
      @(posedge clk); #1;
      rst_n = 0;
      #1;
      chk("rst valid", 64'(res_valid), 64'd0);
      chk("rst data", 64'(res_data), 64'd0);
      chk("rst id", 64'(res_id), 64'd0);
      @(posedge clk); #1;
      rst_n = 1;
      bad = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (res_valid) bad = 1;
      end
      chk("no result after reset", 64'(bad), 64'd0);
      req_valid = '1;
      for (int c = 0; c < 60 && got.size() < 5; c++) begin
         #1;
         if (req_ready != 0) got.push_back($clog2(req_ready));
         @(posedge clk);
      end
      chk("fair count", 64'(got.size()), 64'd5);
      for (int i = 0; i < got.size(); i++)
         chk($sformatf("fair grant%0d", i), 64'(got[i]), 64'(exp_order[i]));
      req_valid = '0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
